syscall_console: RTL and testbench

Syscall service unit at the far end of the processor's syscall path. It accepts a syscall request carrying the `$v0` code and `$a0` argument, and serves it. For print-integer it converts the argument to unsigned decimal ASCII and streams the bytes on a valid/ready byte port. For exit it raises a sticky halt. It stalls the processor via `busy` while a request is in service.

---
 rtl/syscall_console.sv | 154 +++++++++++++++
 tb/tb_syscall_console.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/syscall_console.sv
// Syscall service unit: prints unsigned integers as decimal ASCII on a byte stream,
// raises a sticky halt on exit, and flags unsupported codes.
module syscall_console #(
  parameter logic [31:0] PRINT_CODE   = 32'd1,
  parameter logic [31:0] EXIT_CODE    = 32'd10,
  parameter logic [7:0]  NEWLINE_CHAR = 8'h0A
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic [31:0] code,
  input  logic [31:0] arg,
  output logic        busy,
  output logic        done,
  output logic        bad_code,
  output logic        halt,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int unsigned DW = 32;
  localparam int unsigned ND = 10;
  localparam int unsigned BW = 4 * ND;
  localparam int unsigned CW = 5;
  localparam int unsigned IW = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONVERT,
    S_EMIT,
    S_NEWLINE,
    S_HALT
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] bin_q, bin_d;
  logic [BW-1:0] bcd_q, bcd_d, bcd_adj;
  logic [CW-1:0] step_q, step_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          done_d, bad_d, halt_d, busy_d, tx_valid_d;
  logic [7:0]    tx_data_d;

  // Index of the most significant nonzero digit (0 when all digits are zero).
  function automatic logic [IW-1:0] msd_idx(input logic [BW-1:0] b);
    msd_idx = '0;
    for (int k = 0; k < int'(ND); k++)
      if (b[k*4 +: 4] != 4'd0) msd_idx = IW'(k);
  endfunction

  function automatic logic [3:0] digit_at(input logic [BW-1:0] b, input logic [IW-1:0] i);
    digit_at = 4'd0;
    for (int k = 0; k < int'(ND); k++)
      if (i == IW'(k)) digit_at = b[k*4 +: 4];
  endfunction

  // Double-dabble correction: add 3 to every digit that is 5 or more.
  always_comb begin
    bcd_adj = bcd_q;
    for (int k = 0; k < int'(ND); k++)
      if (bcd_q[k*4 +: 4] >= 4'd5) bcd_adj[k*4 +: 4] = bcd_q[k*4 +: 4] + 4'd3;
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    step_d  = step_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    bad_d   = 1'b0;
    halt_d  = halt;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (code == PRINT_CODE) begin
            state_d = S_CONVERT;
            bin_d   = arg;
            bcd_d   = '0;
            step_d  = '0;
          end else if (code == EXIT_CODE) begin
            state_d = S_HALT;
            halt_d  = 1'b1;
          end else begin
            done_d = 1'b1;
            bad_d  = 1'b1;
          end
        end
      end
      S_CONVERT: begin
        bcd_d  = {bcd_adj[BW-2:0], bin_q[DW-1]};
        bin_d  = {bin_q[DW-2:0], 1'b0};
        step_d = step_q + CW'(1);
        if (step_q == CW'(DW - 1)) begin
          state_d = S_EMIT;
          idx_d   = msd_idx(bcd_d);
        end
      end
      S_EMIT: begin
        if (tx_ready) begin
          if (idx_q == '0) state_d = S_NEWLINE;
          else             idx_d   = idx_q - IW'(1);
        end
      end
      S_NEWLINE: begin
        if (tx_ready) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state so they align with it.
    busy_d     = (state_d != S_IDLE);
    tx_valid_d = (state_d == S_EMIT) || (state_d == S_NEWLINE);
    case (state_d)
      S_EMIT:    tx_data_d = 8'h30 + {4'h0, digit_at(bcd_d, idx_d)};
      S_NEWLINE: tx_data_d = NEWLINE_CHAR;
      default:   tx_data_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      bin_q    <= '0;
      bcd_q    <= '0;
      step_q   <= '0;
      idx_q    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      bad_code <= 1'b0;
      halt     <= 1'b0;
      tx_data  <= 8'h00;
      tx_valid <= 1'b0;
    end else begin
      state_q  <= state_d;
      bin_q    <= bin_d;
      bcd_q    <= bcd_d;
      step_q   <= step_d;
      idx_q    <= idx_d;
      busy     <= busy_d;
      done     <= done_d;
      bad_code <= bad_d;
      halt     <= halt_d;
      tx_data  <= tx_data_d;
      tx_valid <= tx_valid_d;
    end
  end

endmodule

// File: tb/tb_syscall_console.sv
// Self-checking bench for syscall_console: printed text is predicted with $sformatf.
module tb_syscall_console;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic [31:0] code;
  logic [31:0] arg;
  logic        busy, done, bad_code, halt, tx_valid, tx_ready;
  logic [7:0]  tx_data;

  int errors = 0;
  int checks = 0;

  logic [7:0] got[$];
  logic [7:0] expq[$];
  int         hs_edges[$];
  int         stall_bad;
  int         busy_bad;

  syscall_console dut (
    .clk(clk), .rst_n(rst_n), .req(req), .code(code), .arg(arg),
    .busy(busy), .done(done), .bad_code(bad_code), .halt(halt),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  function automatic string q_str(input logic [7:0] q[$]);
    string s = "";
    foreach (q[i]) begin
      if (q[i] == 8'h0A) s = {s, "\\n"};
      else               s = {s, $sformatf("%c", q[i])};
    end
    return s;
  endfunction

  // Reference: decimal text of the unsigned argument followed by a newline.
  task automatic expect_print(input logic [31:0] a);
    string s;
    s = $sformatf("%0d", a);
    expq.delete();
    for (int i = 0; i < s.len(); i++) expq.push_back(8'(s[i]));
    expq.push_back(8'h0A);
  endtask

  // Present a request for one edge; returns at posedge+1 of the accepting edge.
  task automatic issue_req(input logic [31:0] c, input logic [31:0] a);
    req = 1'b1; code = c; arg = a;
    @(posedge clk); #1;
    req = 1'b0; code = '0; arg = '0;
  endtask

  // Sink the byte stream. mode 0: ready always, 1: alternate, 2: random.
  task automatic collect(input int mode, input int max_bytes, output int cyc, output int n_done);
    logic       hs, prev_stall;
    logic [7:0] d, prev_data;
    got.delete(); hs_edges.delete();
    stall_bad = 0; busy_bad = 0; n_done = 0; cyc = 0;
    prev_stall = 1'b0; prev_data = 8'h00;
    for (int k = 1; k <= 3000; k++) begin
      case (mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = ((k % 2) == 1);
        default: tx_ready = 1'($urandom_range(0, 1));
      endcase
      hs = tx_valid && tx_ready;
      d  = tx_data;
      if (prev_stall && tx_valid && d !== prev_data) stall_bad++;
      prev_stall = tx_valid && !tx_ready;
      prev_data  = d;
      @(posedge clk); #1;
      if (hs) begin got.push_back(d); hs_edges.push_back(k); end
      if (done) begin
        n_done++; cyc = k;
        if (busy !== 1'b0) busy_bad++;
        break;
      end else if (busy !== 1'b1) busy_bad++;
      if (max_bytes > 0 && got.size() >= max_bytes) break;
    end
    tx_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 1'b0; code = '0; arg = '0; tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, bad_code, halt, tx_valid} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: got %b want 00000", {busy, done, bad_code, halt, tx_valid});
    end
    checks++;
    if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_print_zero();
    int cyc, nd;
    issue_req(32'd1, 32'd0);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL zero_busy_rise: got %b want 1", busy); end
    collect(0, 0, cyc, nd);
    expect_print(32'd0);
    checks++;
    if (q_str(got) != q_str(expq)) begin errors++; $display("FAIL zero_bytes: got '%s' want '%s'", q_str(got), q_str(expq)); end
    checks++;
    if (hs_edges.size() != 2 || hs_edges[0] != 33 || hs_edges[1] != 34) begin
      errors++; $display("FAIL zero_edges: got %p want 33,34", hs_edges);
    end
    checks++;
    if (nd != 1 || cyc != 34) begin errors++; $display("FAIL zero_done: got done=%0d at edge %0d want 1 at 34", nd, cyc); end
    checks++;
    if (busy_bad != 0) begin errors++; $display("FAIL zero_busy: got %0d bad cycles want 0", busy_bad); end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL zero_done_pulse: got %b want 0", done); end
  endtask

  task automatic test_print_max_bp();
    int cyc, nd, extra;
    issue_req(32'd1, 32'hFFFF_FFFF);
    collect(1, 0, cyc, nd);
    expect_print(32'hFFFF_FFFF);
    checks++;
    if (q_str(got) != q_str(expq) || got.size() != 11) begin
      errors++; $display("FAIL max_bytes: got '%s' want '%s'", q_str(got), q_str(expq));
    end
    checks++;
    if (stall_bad != 0) begin errors++; $display("FAIL max_stall_stable: got %0d changes want 0", stall_bad); end
    extra = 0;
    repeat (40) begin @(posedge clk); #1; if (done) extra++; end
    checks++;
    if (nd != 1 || extra != 0) begin errors++; $display("FAIL max_done_count: got %0d want 1", nd + extra); end
  endtask

  task automatic test_back_to_back();
    int cyc, nd;
    issue_req(32'd1, 32'd1234);
    collect(0, 0, cyc, nd);
    expect_print(32'd1234);
    checks++;
    if (q_str(got) != q_str(expq) || nd != 1) begin
      errors++; $display("FAIL b2b_first: got '%s' done=%0d want '%s' done=1", q_str(got), nd, q_str(expq));
    end
    issue_req(32'd1, 32'd7);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: got busy=%b want 1", busy); end
    collect(0, 0, cyc, nd);
    expect_print(32'd7);
    checks++;
    if (q_str(got) != q_str(expq) || cyc != 34) begin
      errors++; $display("FAIL b2b_second: got '%s' done edge %0d want '%s' edge 34", q_str(got), cyc, q_str(expq));
    end
  endtask

  task automatic test_bad_code_ignored();
    int cyc, nd, vcount;
    issue_req(32'd5, 32'd123);
    checks++;
    if ({done, bad_code, busy, tx_valid} !== 4'b1100) begin
      errors++; $display("FAIL bad_pulse: got %b want 1100", {done, bad_code, busy, tx_valid});
    end
    @(posedge clk); #1;
    checks++;
    if ({done, bad_code, busy} !== 3'b000) begin
      errors++; $display("FAIL bad_after: got %b want 000", {done, bad_code, busy});
    end
    issue_req(32'd1, 32'd555);
    repeat (3) @(posedge clk);
    #1;
    issue_req(32'd1, 32'd999);
    collect(0, 0, cyc, nd);
    expect_print(32'd555);
    checks++;
    if (q_str(got) != q_str(expq) || nd != 1) begin
      errors++; $display("FAIL ignored_req_bytes: got '%s' want '%s'", q_str(got), q_str(expq));
    end
    vcount = 0;
    repeat (40) begin @(posedge clk); #1; if (tx_valid || busy) vcount++; end
    checks++;
    if (vcount != 0) begin errors++; $display("FAIL ignored_req_quiet: got %0d active cycles want 0", vcount); end
  endtask

  task automatic test_random();
    int cyc, nd;
    logic [31:0] a;
    for (int i = 0; i < 8; i++) begin
      a = $urandom >> $urandom_range(0, 31);
      issue_req(32'd1, a);
      collect(2, 0, cyc, nd);
      expect_print(a);
      checks++;
      if (q_str(got) != q_str(expq) || nd != 1 || stall_bad != 0 || busy_bad != 0) begin
        errors++;
        $display("FAIL random_print: arg=%0d got '%s' done=%0d stall=%0d busy=%0d want '%s'",
                 a, q_str(got), nd, stall_bad, busy_bad, q_str(expq));
      end
    end
  endtask

  task automatic test_reset_mid_emit();
    int cyc, nd;
    issue_req(32'd1, 32'd98765);
    collect(0, 2, cyc, nd);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({tx_valid, busy, done} !== 3'b000) begin
      errors++; $display("FAIL rst_mid_emit: got %b want 000", {tx_valid, busy, done});
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    issue_req(32'd1, 32'd42);
    collect(0, 0, cyc, nd);
    expect_print(32'd42);
    checks++;
    if (q_str(got) != q_str(expq) || nd != 1) begin
      errors++; $display("FAIL rst_then_print: got '%s' want '%s'", q_str(got), q_str(expq));
    end
  endtask

  task automatic test_exit();
    int vcount;
    issue_req(32'd10, 32'd0);
    checks++;
    if ({halt, busy, done} !== 3'b110) begin
      errors++; $display("FAIL exit_halt: got %b want 110", {halt, busy, done});
    end
    issue_req(32'd1, 32'd77);
    vcount = 0;
    repeat (60) begin @(posedge clk); #1; if (tx_valid || done || !halt || !busy) vcount++; end
    checks++;
    if (vcount != 0) begin errors++; $display("FAIL exit_sticky: got %0d bad cycles want 0", vcount); end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({halt, busy} !== 2'b00) begin errors++; $display("FAIL exit_reset: got %b want 00", {halt, busy}); end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_print_zero();
    test_print_max_bp();
    test_back_to_back();
    test_bad_code_ignored();
    test_random();
    test_reset_mid_emit();
    test_exit();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
